// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg -- shared definitions for the butterfly pipeline.
//   mode_e    : operation encoding carried with every transaction
//   calc_lat  : end-to-end latency of butterfly_pipe for a given multiplier
//               depth (input register + multiplier stages + output register)
// ---------------------------------------------------------------------------
package butterfly_pkg;

  typedef enum logic [1:0] {
    MODE_DIT  = 2'b00,
    MODE_DIF  = 2'b01,
    MODE_MUL  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  function automatic int calc_lat(input int mul_lat);
    return mul_lat + 2;
  endfunction

endpackage

// File: rtl/butterfly_pipe_if.sv
// ---------------------------------------------------------------------------
// butterfly_pipe_if -- transaction bus of the butterfly pipeline.
//   in_valid, mode, swap, a, b, w : one transaction per cycle, no backpressure
//   modulus                       : shared q, only changed while pipe is empty
//   out_valid, a_out, b_out       : results, lane i at bits [i*WIDTH +: WIDTH]
// master drives transactions (bench/upstream), slave is the pipeline.
// ---------------------------------------------------------------------------
interface butterfly_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
);
  import butterfly_pkg::*;

  logic                   in_valid;
  mode_e                  mode;
  logic                   swap;
  logic [LANES*WIDTH-1:0] a;
  logic [LANES*WIDTH-1:0] b;
  logic [LANES*WIDTH-1:0] w;
  logic [WIDTH-1:0]       modulus;
  logic                   out_valid;
  logic [LANES*WIDTH-1:0] a_out;
  logic [LANES*WIDTH-1:0] b_out;

  modport master (
    output in_valid, mode, swap, a, b, w, modulus,
    input  out_valid, a_out, b_out
  );

  modport slave (
    input  in_valid, mode, swap, a, b, w, modulus,
    output out_valid, a_out, b_out
  );

endinterface

// File: rtl/bfly_modmul.sv
// ---------------------------------------------------------------------------
// bfly_modmul -- pipelined (x*w) mod q, latency exactly MUL_LAT cycles.
//   clk : clock
//   x,w : operands (< q), sampled every cycle
//   q   : modulus, quasi-static
//   p   : (x*w) mod q of the operands presented MUL_LAT cycles earlier
// The full product is reduced by restoring shift-subtract: since x,w < q and
// q < 2^WIDTH the quotient fits in WIDTH bits, so WIDTH conditional
// subtractions of q<<i (i = WIDTH-1 .. 0) leave the remainder. Those steps are
// spread evenly over the MUL_LAT register stages; stage 0 also multiplies.
// Data only, no valid tracking and no reset.
// ---------------------------------------------------------------------------
module bfly_modmul #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] p
);

  localparam int STEPS = (WIDTH + MUL_LAT - 1) / MUL_LAT;

  logic [2*WIDTH-1:0] q_ext;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] rem_nxt [MUL_LAT];
  logic [2*WIDTH-1:0] rem_q   [MUL_LAT];

  assign q_ext = {{WIDTH{1'b0}}, q};
  assign prod  = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, w};

  always_comb begin
    for (int s = 0; s < MUL_LAT; s++) begin
      if (s == 0) rem_nxt[s] = prod;
      else        rem_nxt[s] = rem_q[s-1];
      for (int k = 0; k < STEPS; k++) begin
        // Bit position handled by step k of stage s; negative once all
        // WIDTH steps are used up (trailing stages then just delay).
        if (WIDTH - 1 - s*STEPS - k >= 0) begin
          if (rem_nxt[s] >= (q_ext << (WIDTH - 1 - s*STEPS - k)))
            rem_nxt[s] = rem_nxt[s] - (q_ext << (WIDTH - 1 - s*STEPS - k));
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before this edge.
  always_ff @(posedge clk) begin
    for (int s = 0; s < MUL_LAT; s++) rem_q[s] <= rem_nxt[s];
  end

  assign p = rem_q[MUL_LAT-1][WIDTH-1:0];

endmodule

// File: rtl/butterfly_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_pipe -- multi-lane modular NTT butterfly, fixed latency
// MUL_LAT+2 cycles for every mode, one transaction per cycle.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset; clears valid bits and outputs
//   bus     : butterfly_pipe_if.slave (transactions in, results out);
//             its WIDTH/LANES must match this module's parameters
// Modes: DIT a+b*w / a-b*w, DIF a+b / (a-b)*w, MUL x*w (x = swap ? a : b),
// PASS a / b. All arithmetic mod q.
// Build option: define BUTTERFLY_DIF_EN to include the DIF datapath; without
// it mode 01 is executed as DIT with identical latency.
// Structure: input register -> [DIF add/sub] -> bfly_modmul (MUL_LAT) with a
// matching delay line for side data -> [DIT add/sub] -> output register.
// ---------------------------------------------------------------------------
module butterfly_pipe
  import butterfly_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LANES   = 1,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  butterfly_pipe_if.slave  bus
);

  localparam int BW = LANES * WIDTH;

  // Operands are < q, so the sum needs one extra bit before reduction.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] q);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? WIDTH'(s - {1'b0, q}) : s[WIDTH-1:0];
  endfunction

  // x-y+q wraps back into range when x < y because the true result is < q.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] q);
    return (x >= y) ? x - y : x - y + q;
  endfunction

  // ---- mode remap at the input ------------------------------------------
  mode_e in_mode;

  always_comb begin
`ifdef BUTTERFLY_DIF_EN
    in_mode = bus.mode;
`else
    in_mode = (bus.mode == MODE_DIF) ? MODE_DIT : bus.mode;
`endif
  end

  // ---- stage 0: input register ------------------------------------------
  logic          s0_valid;
  mode_e         s0_mode;
  logic          s0_swap;
  logic [BW-1:0] s0_a, s0_b, s0_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s0_valid <= 1'b0;
    else          s0_valid <= bus.in_valid;
  end

  // NOTE: data registers carry no reset; the valid bits alone decide whether
  // their contents mean anything, which keeps reset fan-out to the controls.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s0_mode <= in_mode;
      s0_swap <= bus.swap;
      s0_a    <= bus.a;
      s0_b    <= bus.b;
      s0_w    <= bus.w;
    end
  end

  // ---- multiplier operand select (plus DIF add/sub) ---------------------
  logic [BW-1:0] mul_x;   // operand multiplied by w
  logic [BW-1:0] side_a;  // value travelling alongside the multiplier

  always_comb begin
    mul_x  = s0_b;
    side_a = s0_a;
    for (int l = 0; l < LANES; l++) begin
      case (s0_mode)
        MODE_MUL: if (s0_swap) mul_x[l*WIDTH +: WIDTH] = s0_a[l*WIDTH +: WIDTH];
`ifdef BUTTERFLY_DIF_EN
        MODE_DIF: begin
          mul_x[l*WIDTH +: WIDTH]  = mod_sub(s0_a[l*WIDTH +: WIDTH],
                                             s0_b[l*WIDTH +: WIDTH], bus.modulus);
          side_a[l*WIDTH +: WIDTH] = mod_add(s0_a[l*WIDTH +: WIDTH],
                                             s0_b[l*WIDTH +: WIDTH], bus.modulus);
        end
`endif
        default: ;
      endcase
    end
  end

  // ---- modular multipliers, one per lane --------------------------------
  logic [BW-1:0] prod;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bfly_modmul #(
      .WIDTH   (WIDTH),
      .MUL_LAT (MUL_LAT)
    ) u_modmul (
      .clk (clk),
      .x   (mul_x[l*WIDTH +: WIDTH]),
      .w   (s0_w[l*WIDTH +: WIDTH]),
      .q   (bus.modulus),
      .p   (prod[l*WIDTH +: WIDTH])
    );
  end

  // ---- delay line matching the multiplier depth -------------------------
  logic          d_valid [MUL_LAT];
  mode_e         d_mode  [MUL_LAT];
  logic [BW-1:0] d_a     [MUL_LAT];
  logic [BW-1:0] d_b     [MUL_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LAT; i++) d_valid[i] <= 1'b0;
    end else begin
      d_valid[0] <= s0_valid;
      for (int i = 1; i < MUL_LAT; i++) d_valid[i] <= d_valid[i-1];
    end
  end

  always_ff @(posedge clk) begin
    d_mode[0] <= s0_mode;
    d_a[0]    <= side_a;
    d_b[0]    <= s0_b;
    for (int i = 1; i < MUL_LAT; i++) begin
      d_mode[i] <= d_mode[i-1];
      d_a[i]    <= d_a[i-1];
      d_b[i]    <= d_b[i-1];
    end
  end

  // ---- result formation (DIT add/sub after the multiplier) --------------
  logic [BW-1:0] res_a, res_b;

  always_comb begin
    res_a = '0;
    res_b = '0;
    for (int l = 0; l < LANES; l++) begin
      case (d_mode[MUL_LAT-1])
        MODE_MUL: res_a[l*WIDTH +: WIDTH] = prod[l*WIDTH +: WIDTH];
        MODE_PASS: begin
          res_a[l*WIDTH +: WIDTH] = d_a[MUL_LAT-1][l*WIDTH +: WIDTH];
          res_b[l*WIDTH +: WIDTH] = d_b[MUL_LAT-1][l*WIDTH +: WIDTH];
        end
`ifdef BUTTERFLY_DIF_EN
        MODE_DIF: begin
          res_a[l*WIDTH +: WIDTH] = d_a[MUL_LAT-1][l*WIDTH +: WIDTH];
          res_b[l*WIDTH +: WIDTH] = prod[l*WIDTH +: WIDTH];
        end
`endif
        default: begin
          res_a[l*WIDTH +: WIDTH] = mod_add(d_a[MUL_LAT-1][l*WIDTH +: WIDTH],
                                            prod[l*WIDTH +: WIDTH], bus.modulus);
          res_b[l*WIDTH +: WIDTH] = mod_sub(d_a[MUL_LAT-1][l*WIDTH +: WIDTH],
                                            prod[l*WIDTH +: WIDTH], bus.modulus);
        end
      endcase
    end
  end

  // ---- output register: holds last result while no valid arrives -------
  logic          out_valid_q;
  logic [BW-1:0] a_out_q, b_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
    end else begin
      out_valid_q <= d_valid[MUL_LAT-1];
      if (d_valid[MUL_LAT-1]) begin
        a_out_q <= res_a;
        b_out_q <= res_b;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter WIDTH, default 32: bit width of one coefficient, twiddle and modulus.
REQ-002 Parameter LANES, default 1: number of independent butterfly lanes processed per cycle.
REQ-003 Parameter MUL_LAT, default 4: pipeline depth in cycles of the modular multiplier, must be at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  qualifies mode, swap, a, b and w this cycle.
REQ-007 mode  input  2  operation: 00 DIT, 01 DIF, 10 MUL, 11 PASS.
REQ-008 swap  input  1  in MUL mode, multiply a instead of b.
REQ-009 a, b, w  input  LANES*WIDTH each  per-lane operands and twiddles; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 modulus  input  WIDTH  shared modulus q, quasi-static, changed only while the pipeline is empty.
REQ-011 out_valid  output  1  qualifies a_out and b_out.
REQ-012 a_out, b_out  output  LANES*WIDTH each  per-lane results, same lane packing as the inputs.

Function
REQ-013 Per lane: DIT gives a_out=(a+b*w) mod q and b_out=(a-b*w) mod q.
REQ-014 Per lane: DIF gives a_out=(a+b) mod q and b_out=((a-b)*w) mod q.
REQ-015 Per lane: MUL gives a_out=(x*w) mod q, with x=a when swap=1 and x=b otherwise; b_out=0.
REQ-016 Per lane: PASS gives a_out=a and b_out=b, unmodified.
REQ-017 Operands shall be < q and 2 <= q < 2^WIDTH; all results lie in [0,q-1]; the sum needs no wider than WIDTH+1 bits before conditional subtraction of q.
REQ-018 Latency LAT=MUL_LAT+2 cycles for every mode: out_valid rises exactly LAT rising edges after a cycle with in_valid=1 sampled.
REQ-019 No backpressure; one transaction accepted every cycle; back-to-back and bubbled streams shall emerge in order with gaps preserved.
REQ-020 Mode and swap travel with their transaction; a mode change between consecutive cycles shall not corrupt either transaction.
REQ-021 In DIF mode, the add/sub stage precedes the multiplier and a_out is delayed to align; in DIT mode the multiplier precedes add/sub; both paths total LAT.
REQ-022 While out_valid=0, a_out and b_out hold their last values.
REQ-023 Cycles with in_valid=0 shall not change any valid output or the multiplier result of another transaction.

Reset
REQ-024 Asserting reset_n=0 clears out_valid, a_out, b_out and all pipeline valid bits to 0 asynchronously.
REQ-025 Transactions in flight at reset are dropped; out_valid stays 0 after release until LAT cycles after the next accepted input.
REQ-026 Data pipeline registers other than the outputs need no reset.

Configuration
REQ-027 Macro BUTTERFLY_DIF_EN compiled in: mode 01 performs DIF as in REQ-014.
REQ-028 Macro absent: DIF datapath and its alignment delays are omitted; mode 01 behaves exactly as DIT (00); latency is unchanged.

Structure
REQ-029 Shared package butterfly_pkg holds the mode encodings (MODE_DIT, MODE_DIF, MODE_MUL, MODE_PASS) and the LAT formula as a function of MUL_LAT.
REQ-030 One sub-module bfly_modmul: a pipelined (x*w) mod q with exactly MUL_LAT cycles latency, instantiated once per lane.
REQ-031 Modular add/sub are combinational inside butterfly_pipe between registered stages.

Verification
REQ-032 q=17, a=5, b=3, w=4, DIT -> a_out=0, b_out=10, out_valid LAT cycles later.
REQ-033 Same operands, DIF (macro defined) -> a_out=8, b_out=8; macro undefined -> 0, 10.
REQ-034 q=17, a=5, w=4, MUL, swap=1 -> a_out=3, b_out=0; swap=0 with b=3 -> a_out=12.
REQ-035 q=2^32-5, a=b=q-1, w=1, DIT -> a_out=q-2, b_out=0; PASS -> a_out=b_out=q-1.
REQ-036 LANES=4, 20 back-to-back random mixed-mode transactions with 3 bubbles -> outputs match the golden model in order, gaps preserved.
REQ-037 reset_n pulsed low with 3 transactions in flight -> outputs 0 immediately; no out_valid for them; the next transaction appears after exactly LAT cycles.
